modulo_mux_scan_n: RTL and testbench

Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake. Two modes:
- Manual: one-shot select driven by `input_sel`.
- Auto-scan: an internal pointer walks the channels, holding each one for DWELL cycles before sampling it.

Sits between the channel sources and the display/serial stage. Generalises the fixed 8:1 combinational selector in width, channel count and mode.

---
 rtl/modulo_mux_pkg.sv | 14 +
 rtl/modulo_mux_sel_n.sv | 22 ++
 rtl/modulo_mux_scan_n.sv | 180 ++++++++++++++++++
 tb/tb_modulo_mux_scan_n.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_mux_pkg.sv
// Shared types for the modulo_mux_scan_n channel multiplexer: FSM state encoding and mode values.
package modulo_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MANUAL  = 2'd1,
    ST_DWELL   = 2'd2,
    ST_PRESENT = 2'd3
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/modulo_mux_sel_n.sv
// Combinational N:1 selector over a flat bus of CHANNELS x WIDTH-bit channels.
// A select at or beyond CHANNELS yields all-zero data.
module modulo_mux_sel_n
  import modulo_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [WIDTH-1:0]          data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(sel_i) == k) data_o = data_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/modulo_mux_scan_n.sv
// N-channel registered multiplexer with valid/ready output, manual select or dwell-timed auto-scan.
// Optional macro MUX_SCAN_MASK_EN adds a chan_mask port that restricts which channels the scan visits.
module modulo_mux_scan_n
  import modulo_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] input_e,
  input  logic [SEL_W-1:0]          input_sel,
  input  logic                      mode,
  input  logic                      enable,
  input  logic                      out_ready,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       chan_mask,
`endif
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      wrap
);

  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q, wrap_d;

  logic               load_ok;
  logic               accept;
  logic [SEL_W-1:0]   sel_mux;
  logic [WIDTH-1:0]   sel_data;
  logic               scan_ok;
  logic [SEL_W-1:0]   first_ch;
  logic [SEL_W-1:0]   next_ch;
  logic               next_wraps;

`ifdef MUX_SCAN_MASK_EN
  // Lowest set mask bit at or above start; falls back to the lowest set bit overall (circular search).
  function automatic logic [SEL_W-1:0] seek_ch(input logic [CHANNELS-1:0] m, input int start);
    logic [SEL_W-1:0] hit_fwd;
    logic [SEL_W-1:0] hit_any;
    logic             found_fwd;
    hit_fwd   = '0;
    hit_any   = '0;
    found_fwd = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (m[k]) begin
        hit_any = SEL_W'(k);
        if (k >= start) begin
          hit_fwd   = SEL_W'(k);
          found_fwd = 1'b1;
        end
      end
    end
    return found_fwd ? hit_fwd : hit_any;
  endfunction

  assign scan_ok    = |chan_mask;
  assign first_ch   = seek_ch(chan_mask, 0);
  assign next_ch    = seek_ch(chan_mask, (ptr_q == PTR_LAST) ? 0 : int'(ptr_q) + 1);
  assign next_wraps = (next_ch < ptr_q);
`else
  assign scan_ok    = 1'b1;
  assign first_ch   = '0;
  assign next_ch    = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  assign next_wraps = (ptr_q == PTR_LAST);
`endif

  assign load_ok = !out_valid_q || out_ready;
  assign accept  = out_valid_q && out_ready;
  assign sel_mux = (state_q == ST_MANUAL) ? input_sel : ptr_q;

  modulo_mux_sel_n #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_sel (
    .data_i (input_e),
    .sel_i  (sel_mux),
    .data_o (sel_data)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    wrap_d      = 1'b0;
    if (accept) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (mode == MODE_MANUAL) begin
            state_d = ST_MANUAL;
          end else if (scan_ok) begin
            state_d = ST_DWELL;
            ptr_d   = first_ch;
            cnt_d   = '0;
          end
        end
      end
      // Mode and enable are only re-evaluated once no beat is pending.
      ST_MANUAL: begin
        if (load_ok) begin
          if (enable && mode == MODE_MANUAL) begin
            out_d       = sel_data;
            out_ch_d    = input_sel;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DWELL: begin
        if (!enable || !scan_ok) begin
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (load_ok) begin
          out_d       = sel_data;
          out_ch_d    = ptr_q;
          out_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          if (enable && mode == MODE_SCAN && scan_ok) begin
            state_d = ST_DWELL;
            cnt_d   = '0;
            ptr_d   = next_ch;
            wrap_d  = next_wraps;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_modulo_mux_scan_n.sv
// Self-checking bench for modulo_mux_scan_n: an 8-channel/4-bit/DWELL=4 instance and a 5-channel/8-bit/DWELL=2 instance.
module tb_modulo_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_mode, a_en, a_rdy;
  logic [31:0] a_in;
  logic [2:0]  a_sel;
  logic [3:0]  a_out;
  logic [2:0]  a_ch;
  logic        a_vld, a_wrap;

  logic        b_reset, b_mode, b_en, b_rdy;
  logic [39:0] b_in;
  logic [2:0]  b_sel;
  logic [7:0]  b_out;
  logic [2:0]  b_ch;
  logic        b_vld, b_wrap;

`ifdef MUX_SCAN_MASK_EN
  logic [7:0]  a_mask;
  logic [4:0]  b_mask;
`endif

  int checks = 0;
  int errors = 0;

  modulo_mux_scan_n #(.WIDTH(4), .CHANNELS(8), .DWELL(4)) dut_a (
    .clk(clk), .reset(a_reset), .input_e(a_in), .input_sel(a_sel), .mode(a_mode),
    .enable(a_en), .out_ready(a_rdy),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(a_mask),
`endif
    .out(a_out), .out_ch(a_ch), .out_valid(a_vld), .wrap(a_wrap)
  );

  modulo_mux_scan_n #(.WIDTH(8), .CHANNELS(5), .DWELL(2)) dut_b (
    .clk(clk), .reset(b_reset), .input_e(b_in), .input_sel(b_sel), .mode(b_mode),
    .enable(b_en), .out_ready(b_rdy),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(b_mask),
`endif
    .out(b_out), .out_ch(b_ch), .out_valid(b_vld), .wrap(b_wrap)
  );

  // Reference: channel k of the bus, zero when the index is past the last channel.
  function automatic logic [3:0] ref_a(input int ch);
    if (ch >= 8) return 4'd0;
    return a_in[ch*4 +: 4];
  endfunction

  function automatic logic [7:0] ref_b(input int ch);
    if (ch >= 5) return 8'd0;
    return b_in[ch*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    step(); step();
    checks++;
    if (a_vld !== 1'b0 || a_wrap !== 1'b0) begin
      errors++; $display("FAIL reset_a_ctrl: vld=%0b wrap=%0b expected 0 0", a_vld, a_wrap);
    end
    checks++;
    if (a_out !== 4'd0 || a_ch !== 3'd0) begin
      errors++; $display("FAIL reset_a_data: out=%0d ch=%0d expected 0 0", a_out, a_ch);
    end
    checks++;
    if (b_vld !== 1'b0 || b_wrap !== 1'b0 || b_out !== 8'd0 || b_ch !== 3'd0) begin
      errors++; $display("FAIL reset_b: vld=%0b wrap=%0b out=%0d ch=%0d expected all 0", b_vld, b_wrap, b_out, b_ch);
    end
    a_reset = 1'b0; b_reset = 1'b0;
  endtask

  task automatic test_manual_basic();
    int n;
    for (int k = 0; k < 8; k++) a_in[k*4 +: 4] = 4'(k + 1);
    a_mode = 1'b0; a_rdy = 1'b1; a_sel = 3'd5; a_en = 1'b1;
    n = 0;
    do begin step(); n++; end while (!a_vld && n < 10);
    checks++;
    if (a_vld !== 1'b1) begin
      errors++; $display("FAIL manual_first_beat: vld=%0b after %0d cycles, expected 1", a_vld, n);
    end
    checks++;
    if (a_out !== 4'd6 || a_ch !== 3'd5) begin
      errors++; $display("FAIL manual_sel5: out=%0d ch=%0d expected 6 5", a_out, a_ch);
    end
  endtask

  task automatic test_manual_backpressure();
    a_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_sel = (i == 0) ? 3'd7 : 3'd2;
      step();
      checks++;
      if (a_vld !== 1'b1 || a_out !== 4'd6 || a_ch !== 3'd5) begin
        errors++; $display("FAIL manual_hold: vld=%0b out=%0d ch=%0d expected 1 6 5", a_vld, a_out, a_ch);
      end
    end
    a_rdy = 1'b1;
    step();
    checks++;
    if (a_vld !== 1'b1 || a_out !== 4'd3 || a_ch !== 3'd2) begin
      errors++; $display("FAIL manual_release: vld=%0b out=%0d ch=%0d expected 1 3 2", a_vld, a_out, a_ch);
    end
  endtask

  task automatic test_back_to_back();
    logic pv, pr;
    logic [2:0] ps, pch;
    logic [3:0] pout;
    int n;
    a_in = $urandom;
    for (int i = 0; i < 150; i++) begin
      a_sel = 3'($urandom_range(0, 7));
      a_rdy = ($urandom_range(0, 3) != 0);
      pv = a_vld; pr = a_rdy; ps = a_sel; pch = a_ch; pout = a_out;
      step();
      checks++;
      if (pv && !pr) begin
        if (a_vld !== 1'b1 || a_ch !== pch || a_out !== pout) begin
          errors++; $display("FAIL b2b_hold: vld=%0b ch=%0d out=%0d expected 1 %0d %0d", a_vld, a_ch, a_out, pch, pout);
        end
      end else if (a_vld !== 1'b1 || a_ch !== ps || a_out !== ref_a(int'(ps))) begin
        errors++; $display("FAIL b2b_load: vld=%0b ch=%0d out=%0d expected 1 %0d %0d", a_vld, a_ch, a_out, ps, ref_a(int'(ps)));
      end
    end
    a_en = 1'b0; a_rdy = 1'b1;
    n = 0;
    do begin step(); n++; end while (a_vld && n < 5);
    checks++;
    if (a_vld !== 1'b0) begin
      errors++; $display("FAIL manual_drain: vld=%0b expected 0", a_vld);
    end
  endtask

  task automatic test_scan();
    logic pv, pr;
    logic [2:0] pch;
    logic [3:0] pout;
    int exp_ch, beats, cyc, last, wraps;
    a_in = $urandom;
    a_mode = 1'b1; a_en = 1'b1; a_rdy = 1'b1;
    exp_ch = 0; beats = 0; cyc = 0; last = 0; wraps = 0;
    while (beats < 40 && cyc < 600) begin
      a_rdy = (beats < 9) ? 1'b1 : ($urandom_range(0, 2) != 0);
      pv = a_vld; pr = a_rdy; pch = a_ch; pout = a_out;
      step(); cyc++;
      if (a_wrap === 1'b1 && beats <= 9) wraps++;
      checks++;
      if (a_wrap !== (pv && pr && pch == 3'd7)) begin
        errors++; $display("FAIL scan_wrap: wrap=%0b prev_ch=%0d prev_accept=%0b", a_wrap, pch, pv && pr);
      end
      if (pv && !pr) begin
        checks++;
        if (a_vld !== 1'b1 || a_ch !== pch || a_out !== pout) begin
          errors++; $display("FAIL scan_hold: vld=%0b ch=%0d out=%0d expected 1 %0d %0d", a_vld, a_ch, a_out, pch, pout);
        end
      end else if (a_vld) begin
        checks++;
        if (a_ch !== 3'(exp_ch) || a_out !== ref_a(exp_ch)) begin
          errors++; $display("FAIL scan_beat: ch=%0d out=%0d expected %0d %0d", a_ch, a_out, exp_ch, ref_a(exp_ch));
        end
        if (beats > 0 && beats < 9) begin
          checks++;
          if (cyc - last != 5) begin
            errors++; $display("FAIL scan_spacing: %0d cycles between beats, expected 5", cyc - last);
          end
        end
        last = cyc; beats++; exp_ch = (exp_ch + 1) % 8;
      end
    end
    checks++;
    if (beats < 40) begin
      errors++; $display("FAIL scan_timeout: %0d beats seen, expected 40", beats);
    end
    checks++;
    if (wraps != 1) begin
      errors++; $display("FAIL scan_wrap_count: %0d wraps in first 9 beats, expected 1", wraps);
    end
  endtask

  task automatic test_scan_stall_reset();
    logic [3:0] held;
    int n;
    a_rdy = 1'b1;
    n = 0;
    do begin step(); n++; end while (!(a_vld && a_ch == 3'd3) && n < 100);
    checks++;
    if (!(a_vld === 1'b1 && a_ch === 3'd3)) begin
      errors++; $display("FAIL stall_find_ch3: vld=%0b ch=%0d expected 1 3", a_vld, a_ch);
    end
    held = ref_a(3);
    a_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_en = (i < 5);
      step();
      checks++;
      if (a_vld !== 1'b1 || a_ch !== 3'd3 || a_out !== held) begin
        errors++; $display("FAIL stall_hold: vld=%0b ch=%0d out=%0d expected 1 3 %0d", a_vld, a_ch, a_out, held);
      end
    end
    a_reset = 1'b1; a_en = 1'b1;
    step();
    checks++;
    if (a_vld !== 1'b0 || a_out !== 4'd0 || a_ch !== 3'd0 || a_wrap !== 1'b0) begin
      errors++; $display("FAIL stall_reset: vld=%0b out=%0d ch=%0d wrap=%0b expected 0 0 0 0", a_vld, a_out, a_ch, a_wrap);
    end
    a_reset = 1'b0; a_rdy = 1'b1;
    n = 0;
    do begin step(); n++; end while (!a_vld && n < 20);
    checks++;
    if (a_vld !== 1'b1 || a_ch !== 3'd0 || a_out !== ref_a(0)) begin
      errors++; $display("FAIL restart_ch0: vld=%0b ch=%0d out=%0d expected 1 0 %0d", a_vld, a_ch, a_out, ref_a(0));
    end
    a_en = 1'b0;
    step(); step();
  endtask

  task automatic test_nonpow2();
    logic pv, pr;
    logic [2:0] pch;
    int exp_ch, beats, cyc, last, n;
    b_in = {$urandom, $urandom};
    b_mode = 1'b1; b_en = 1'b1; b_rdy = 1'b1;
    exp_ch = 0; beats = 0; cyc = 0; last = 0;
    while (beats < 6 && cyc < 100) begin
      pv = b_vld; pr = b_rdy; pch = b_ch;
      step(); cyc++;
      checks++;
      if (b_wrap !== (pv && pr && pch == 3'd4)) begin
        errors++; $display("FAIL np2_wrap: wrap=%0b prev_ch=%0d", b_wrap, pch);
      end
      if (b_vld && !(pv && !pr)) begin
        checks++;
        if (b_ch !== 3'(exp_ch) || b_out !== ref_b(exp_ch)) begin
          errors++; $display("FAIL np2_beat: ch=%0d out=%0d expected %0d %0d", b_ch, b_out, exp_ch, ref_b(exp_ch));
        end
        if (beats > 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++; $display("FAIL np2_spacing: %0d cycles, expected 3", cyc - last);
          end
        end
        last = cyc; beats++; exp_ch = (exp_ch + 1) % 5;
      end
    end
    checks++;
    if (beats < 6) begin
      errors++; $display("FAIL np2_timeout: %0d beats, expected 6", beats);
    end
    b_mode = 1'b0; b_sel = 3'd6;
    n = 0;
    do begin step(); n++; end while (!(b_vld && b_ch == 3'd6) && n < 30);
    checks++;
    if (b_vld !== 1'b1 || b_ch !== 3'd6 || b_out !== 8'd0) begin
      errors++; $display("FAIL np2_sel6: vld=%0b ch=%0d out=%0d expected 1 6 0", b_vld, b_ch, b_out);
    end
    b_sel = 3'd7;
    step();
    checks++;
    if (b_vld !== 1'b1 || b_ch !== 3'd7 || b_out !== 8'd0) begin
      errors++; $display("FAIL np2_sel7: vld=%0b ch=%0d out=%0d expected 1 7 0", b_vld, b_ch, b_out);
    end
    b_sel = 3'd3;
    step();
    checks++;
    if (b_vld !== 1'b1 || b_ch !== 3'd3 || b_out !== ref_b(3)) begin
      errors++; $display("FAIL np2_sel3: vld=%0b ch=%0d out=%0d expected 1 3 %0d", b_vld, b_ch, b_out, ref_b(3));
    end
    b_en = 1'b0;
    step(); step();
  endtask

`ifdef MUX_SCAN_MASK_EN
  task automatic test_mask();
    logic pv, pr;
    logic [2:0] pch;
    int exp_list[4];
    int beats, cyc;
    exp_list = '{2, 5, 7, 2};
    a_reset = 1'b1; step(); a_reset = 1'b0;
    a_in = $urandom;
    a_mask = 8'b1010_0100; a_mode = 1'b1; a_en = 1'b1; a_rdy = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 100) begin
      pv = a_vld; pr = a_rdy; pch = a_ch;
      step(); cyc++;
      checks++;
      if (a_wrap !== (pv && pr && pch == 3'd7)) begin
        errors++; $display("FAIL mask_wrap: wrap=%0b prev_ch=%0d", a_wrap, pch);
      end
      if (a_vld && !(pv && !pr)) begin
        checks++;
        if (a_ch !== 3'(exp_list[beats]) || a_out !== ref_a(exp_list[beats])) begin
          errors++; $display("FAIL mask_beat: ch=%0d out=%0d expected %0d", a_ch, a_out, exp_list[beats]);
        end
        beats++;
      end
    end
    checks++;
    if (beats < 4) begin
      errors++; $display("FAIL mask_timeout: %0d beats, expected 4", beats);
    end
    a_en = 1'b0;
    step(); step();
    a_mask = 8'd0; a_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (a_vld !== 1'b0) begin
        errors++; $display("FAIL mask_zero: vld=%0b expected 0", a_vld);
      end
    end
    a_en = 1'b0; a_mask = 8'hFF;
    step();
  endtask
`endif

  initial begin
    a_reset = 1'b1; a_mode = 1'b0; a_en = 1'b0; a_rdy = 1'b0; a_in = '0; a_sel = '0;
    b_reset = 1'b1; b_mode = 1'b0; b_en = 1'b0; b_rdy = 1'b0; b_in = '0; b_sel = '0;
`ifdef MUX_SCAN_MASK_EN
    a_mask = 8'hFF; b_mask = 5'h1F;
`endif
    test_reset();
    test_manual_basic();
    test_manual_backpressure();
    test_back_to_back();
    test_scan();
    test_scan_stall_reset();
    test_nonpow2();
`ifdef MUX_SCAN_MASK_EN
    test_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
